// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
// Holds the receiver state enum, data width and the clocks-per-bit function.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for an asynchronous input, resets to 1.
// Ports: clk, rst (async, active-high), d (async in), q (synchronized out).
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-entry valid/ready holding register.
// Ports: CLK, RESET (async high), RXD (serial in, idle high),
//   rx_data/rx_valid/rx_ready (holding register handshake),
//   rx_frame_err, rx_overrun (1-cycle pulses), busy (FSM not IDLE).
// Optional: define UART_RX_PARITY_EN for an even-parity bit after bit 7.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD        = 115200
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RXD,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_frame_err,
    output logic              rx_overrun,
    output logic              busy
);

    localparam int N  = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int H  = N / 2;
    localparam int CW = $clog2(N);

    localparam logic [CW-1:0] LOAD_H = CW'(H - 1);
    localparam logic [CW-1:0] LOAD_N = CW'(N - 1);

    if (N < 4) begin : g_bad_rate
        $error("uart_rx: CLK_FREQ_HZ/BAUD must be at least 4");
    end

    logic              rxd_s;
    rx_state_t         state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [2:0]        bit_idx, bit_idx_nx;
    logic [DATA_W-1:0] shreg, shreg_nx;
    logic              done_q, done_nx;
    logic              ferr_q, ferr_nx;
    logic              tick;
`ifdef UART_RX_PARITY_EN
    logic              par_q, par_nx;
    logic              par_ok;
`endif

    uart_rx_sync u_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (RXD),
        .q   (rxd_s)
    );

    assign tick = (cnt == '0);
    assign busy = (state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign par_ok = ~^{shreg, par_q};
`endif

    always_comb begin
        state_nx   = state;
        cnt_nx     = tick ? cnt : cnt - CW'(1);
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        done_nx    = 1'b0;
        ferr_nx    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nx     = par_q;
`endif
        unique case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_nx = START;
                    cnt_nx   = LOAD_H;
                end
            end
            START: begin
                // Mid-start-bit check rejects glitches shorter than H.
                if (tick) begin
                    if (rxd_s) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx   = DATA;
                        cnt_nx     = LOAD_N;
                        bit_idx_nx = '0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_nx     = LOAD_N;
                    shreg_nx   = {rxd_s, shreg[DATA_W-1:1]};
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    cnt_nx   = LOAD_N;
                    par_nx   = rxd_s;
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                // Leave mid-stop-bit so a start bit right after is caught.
                if (tick) begin
`ifdef UART_RX_PARITY_EN
                    done_nx = rxd_s & par_ok;
                    ferr_nx = ~(rxd_s & par_ok);
`else
                    done_nx = rxd_s;
                    ferr_nx = ~rxd_s;
`endif
                    state_nx = rxd_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rxd_s) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_idx_nx;
            shreg   <= shreg_nx;
            done_q  <= done_nx;
            ferr_q  <= ferr_nx;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_nx;
`endif
        end
    end

    // shreg stays stable for H+N cycles after the stop sample,
    // so the holding register can load it one cycle later.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= ferr_q;
            rx_overrun   <= 1'b0;
            unique case (1'b1)
                done_q && (!rx_valid || rx_ready): begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end
                done_q && rx_valid && !rx_ready: begin
                    rx_overrun <= 1'b1;
                end
                !done_q && rx_valid && rx_ready: begin
                    rx_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at N=10, H=5.
// Frames are built bit by bit; expectations come from a frame-level model.
module tb_uart_rx;

    localparam int CLK_FREQ_HZ = 1000000;
    localparam int BAUD        = 100000;
    localparam int N           = CLK_FREQ_HZ / BAUD;
    localparam int H           = N / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // Pin driven just after edge e0: two sync flops, FSM sees it at e0+3 (t0).
    localparam int LAT = 3 + H + (9 + PAR) * N + 1;

    logic       CLK;
    logic       RESET;
    logic       RXD;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       busy;

    int checks;
    int errors;
    int fe_cnt;
    int ov_cnt;
    int vhi_cnt;
    int fe0, ov0, vh0, n;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_rx #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD        (BAUD)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .RXD          (RXD),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .busy         (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (!RESET) begin
            if (rx_valid) vhi_cnt <= vhi_cnt + 1;
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (rx_frame_err) fe_cnt <= fe_cnt + 1;
            if (rx_overrun) ov_cnt <= ov_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        RXD = b;
        step(N);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop,
                              input bit pflip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR != 0) send_bit((^d) ^ pflip);
        send_bit(stop);
    endtask

    // A frame is delivered only with a good stop bit and good parity.
    function automatic bit model_ok(input bit stop, input bit pflip);
        return stop && !((PAR != 0) && pflip);
    endfunction

    task automatic compare_q(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check(tag, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic mark();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        vh0 = vhi_cnt;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        fe_cnt   = 0;
        ov_cnt   = 0;
        vhi_cnt  = 0;
        RESET    = 1'b1;
        RXD      = 1'b1;
        rx_ready = 1'b0;
        step(3);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", rx_frame_err, 0);
        check("rst_ovr", rx_overrun, 0);
        RESET = 1'b0;
        step(5);

        // Single byte, latency from pin fall to rx_valid
        mark();
        n = 0;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                while (!rx_valid && n < LAT + 20) begin
                    step(1);
                    n++;
                end
            end
        join
        check("single_latency", n, LAT);
        check("single_data", rx_data, 8'hA5);
        step(N);
        check("single_busy", busy, 0);
        check("single_valid_hold", rx_valid, 1);
        check("single_ferr", fe_cnt - fe0, 0);
        check("single_ovr", ov_cnt - ov0, 0);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        check("single_accept_clr", rx_valid, 0);
        exp_q.push_back(8'hA5);
        compare_q("single_got");

        // Back-to-back with accept: fixed then random bytes
        mark();
        rx_ready = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        for (int i = 0; i < 5; i++) exp_q.push_back(8'($urandom));
        for (int i = 0; i < exp_q.size(); i++) send_frame(exp_q[i], 1'b1, 1'b0);
        step(2 * N);
        check("b2b_pulses", vhi_cnt - vh0, exp_q.size());
        check("b2b_ovr", ov_cnt - ov0, 0);
        check("b2b_ferr", fe_cnt - fe0, 0);
        compare_q("b2b_data");

        // Overrun
        mark();
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        step(2 * N);
        check("ovr_pulse", ov_cnt - ov0, 1);
        check("ovr_keep", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1);
        check("ovr_ferr", fe_cnt - fe0, 0);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        step(1);
        exp_q.push_back(8'h11);
        compare_q("ovr_got");

        // Glitch on the start bit
        mark();
        RXD = 1'b0;
        step(3);
        check("glitch_busy_hi", busy, 1);
        RXD = 1'b1;
        step(3 * N);
        check("glitch_busy", busy, 0);
        check("glitch_valid", rx_valid, 0);
        check("glitch_ferr", fe_cnt - fe0, 0);
        check("glitch_ovr", ov_cnt - ov0, 0);

        // Framing error and break
        mark();
        send_frame(8'h55, 1'b0, 1'b0);
        step(50);
        check("brk_busy", busy, 1);
        check("brk_ferr", fe_cnt - fe0, 1);
        check("brk_valid", rx_valid, 0);
        RXD = 1'b1;
        step(5);
        check("brk_exit", busy, 0);
        rx_ready = 1'b1;
        send_frame(8'h77, 1'b1, 1'b0);
        step(2 * N);
        exp_q.push_back(8'h77);
        compare_q("brk_next");

        // Reset mid-frame with a byte already held
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0);
        step(2 * N);
        check("rmid_held", rx_valid, 1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(n[0] ^ i[0]);
        #2;
        RESET = 1'b1;
        #1;
        check("rmid_valid", rx_valid, 0);
        check("rmid_data", rx_data, 0);
        check("rmid_busy", busy, 0);
        RXD = 1'b1;
        step(3);
        RESET = 1'b0;
        step(2 * N);
        got_q.delete();
        mark();
        rx_ready = 1'b1;
        send_frame(8'h42, 1'b1, 1'b0);
        step(2 * N);
        check("rmid_ferr", fe_cnt - fe0, 0);
        exp_q.push_back(8'h42);
        compare_q("rmid_got");

`ifdef UART_RX_PARITY_EN
        // Parity error then the same byte with correct parity
        mark();
        send_frame(8'h03, 1'b1, 1'b1);
        step(2 * N);
        check("par_ferr", fe_cnt - fe0, 1);
        check("par_drop", got_q.size(), 0);
        send_frame(8'h03, 1'b1, 1'b0);
        step(2 * N);
        exp_q.push_back(8'h03);
        compare_q("par_good");
`endif

        // Random frames with occasional bad stop/parity, one idle bit gap
        mark();
        rx_ready = 1'b1;
        begin
            int exp_fe;
            exp_fe = 0;
            for (int i = 0; i < 8; i++) begin
                logic [7:0] d;
                bit st, pf;
                d  = 8'($urandom);
                st = ($urandom_range(0, 3) != 0);
                pf = (PAR != 0) && ($urandom_range(0, 3) == 0);
                send_frame(d, st, pf);
                send_bit(1'b1);
                if (model_ok(st, pf)) exp_q.push_back(d);
                else exp_fe++;
            end
            step(2 * N);
            check("rnd_ferr", fe_cnt - fe0, exp_fe);
        end
        check("rnd_ovr", ov_cnt - ov0, 0);
        compare_q("rnd_data");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
